// File: rtl/hgcal_pkg.sv
// hgcal_pkg: shared constants, thresholds and state encoding for the HGCAL input packer
package hgcal_pkg;
    localparam int IN_WIDTH  = 8;
    localparam int NUM_CELLS = 48;
    localparam int QBITS     = 2;
    localparam int FRAME_W   = NUM_CELLS * QBITS;
    localparam logic [7:0] THRESH0 = 8'd16;
    localparam logic [7:0] THRESH1 = 8'd64;
    localparam logic [7:0] THRESH2 = 8'd160;
    typedef enum logic [1:0] {FILL, HOLD, RESYNC} state_t;
endpackage

// File: rtl/hgcal_cell_quantizer.sv
// hgcal_cell_quantizer: maps one unsigned charge to a 4-level code; equal-to-threshold takes the higher code
module hgcal_cell_quantizer
    import hgcal_pkg::*;
#(
    parameter int IN_WIDTH = hgcal_pkg::IN_WIDTH,
    parameter int QBITS = hgcal_pkg::QBITS,
    parameter logic [IN_WIDTH-1:0] T0 = IN_WIDTH'(THRESH0),
    parameter logic [IN_WIDTH-1:0] T1 = IN_WIDTH'(THRESH1),
    parameter logic [IN_WIDTH-1:0] T2 = IN_WIDTH'(THRESH2)
) (
    input  logic [IN_WIDTH-1:0] x,
    output logic [QBITS-1:0]    code
);
    always_comb code = x < T0 ? QBITS'(0) : x < T1 ? QBITS'(1) : x < T2 ? QBITS'(2) : QBITS'(3);
endmodule

// File: rtl/hgcal_input_packer.sv
// hgcal_input_packer: quantizes a stream of cell charges and packs a full frame for the first LUT layer,
// dropping frames whose length does not match NUM_CELLS.
module hgcal_input_packer
    import hgcal_pkg::*;
#(
    parameter int IN_WIDTH = hgcal_pkg::IN_WIDTH,
    parameter int NUM_CELLS = hgcal_pkg::NUM_CELLS,
    parameter int QBITS = hgcal_pkg::QBITS,
    parameter logic [IN_WIDTH-1:0] THRESH0 = IN_WIDTH'(hgcal_pkg::THRESH0),
    parameter logic [IN_WIDTH-1:0] THRESH1 = IN_WIDTH'(hgcal_pkg::THRESH1),
    parameter logic [IN_WIDTH-1:0] THRESH2 = IN_WIDTH'(hgcal_pkg::THRESH2)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_WIDTH-1:0]        s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [NUM_CELLS*QBITS-1:0] m_data,
    output logic                       err_frame
);
    localparam int CW = $clog2(NUM_CELLS);
    state_t state, state_next;
    logic [CW-1:0] count;
    logic [QBITS-1:0] code;
    logic accept, last_cell, fill_beat;
    assign accept = s_valid && s_ready;
    assign last_cell = count == CW'(NUM_CELLS - 1);
    assign fill_beat = state == FILL && accept;
    hgcal_cell_quantizer #(
        .IN_WIDTH(IN_WIDTH),
        .QBITS(QBITS),
        .T0(THRESH0),
        .T1(THRESH1),
        .T2(THRESH2)
    ) u_quant (
        .x(s_data),
        .code(code)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= FILL;
        else state <= state_next;
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && last_cell) state_next = s_last ? HOLD : RESYNC;
            HOLD:    if (m_ready) state_next = FILL;
            RESYNC:  if (accept && s_last) state_next = FILL;
            default: state_next = FILL;
        endcase
    end
    always_comb begin
        s_ready = state != HOLD;
        m_valid = state == HOLD;
    end
    // Stale slots from a discarded frame are harmless: a good frame rewrites every slot before HOLD.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            count <= '0;
            m_data <= '0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= fill_beat && (s_last != last_cell);
            if (fill_beat) begin
                m_data[count*QBITS +: QBITS] <= code;
                count <= (s_last || last_cell) ? '0 : count + CW'(1);
            end
        end
endmodule

// File: tb/tb_hgcal_input_packer.sv
// tb_hgcal_input_packer: randomized frames checked against a threshold/packing reference model
module tb_hgcal_input_packer;
    logic clk = 1'b0, rst = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic [7:0] s_data = '0;
    logic s_ready, m_valid, err_frame;
    logic [95:0] m_data;
    int total = 0, bad = 0, err_seen = 0, mv_seen = 0;
    logic [7:0] vals [64];

    hgcal_input_packer dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_frame === 1'b1) err_seen++;
        if (m_valid === 1'b1) mv_seen++;
    end

    function automatic logic [1:0] ref_q(input logic [7:0] x);
        if (x >= 8'd160) return 2'd3;
        if (x >= 8'd64) return 2'd2;
        if (x >= 8'd16) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [95:0] ref_frame();
        logic [95:0] r;
        for (int i = 0; i < 48; i++) r[i*2 +: 2] = ref_q(vals[i]);
        return r;
    endfunction

    function automatic logic [7:0] pick();
        logic [7:0] edges [8];
        edges = '{8'd15, 8'd16, 8'd63, 8'd64, 8'd159, 8'd160, 8'd0, 8'd255};
        return ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 7)] : 8'($urandom);
    endfunction

    task automatic randomize_vals();
        for (int i = 0; i < 64; i++) vals[i] = pick();
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_ready: s_ready=%b required 1", s_ready);
        end
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_data = 8'($urandom);
        s_last = 1'($urandom);
    endtask

    task automatic send(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle();
            beat(vals[i], i == n - 1);
        end
    endtask

    task automatic expect_frame(input int hold);
        logic [95:0] exp;
        exp = ref_frame();
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = (hold == 0);
        total++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL frame_valid: m_valid=%b s_ready=%b required 1/0", m_valid, s_ready);
        end
        total++;
        if (m_data !== exp) begin
            bad++;
            $display("FAIL frame_data: m_data=%h required %h", m_data, exp);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            total++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== exp) begin
                bad++;
                $display("FAIL frame_hold: cycle %0d m_valid=%b s_ready=%b m_data=%h required 1/0/%h",
                         k, m_valid, s_ready, m_data, exp);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL frame_release: m_valid=%b s_ready=%b required 0/1", m_valid, s_ready);
        end
    endtask

    task automatic check_slot(input int slot, input logic [1:0] code);
        total++;
        if (m_data[slot*2 +: 2] !== code) begin
            bad++;
            $display("FAIL slot_%0d: code=%0d required %0d", slot, m_data[slot*2 +: 2], code);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (m_valid !== 1'b0 || err_frame !== 1'b0 || m_data !== '0) begin
            bad++;
            $display("FAIL %s: m_valid=%b err_frame=%b m_data=%h required 0/0/0", tag, m_valid, err_frame, m_data);
        end
    endtask

    task automatic test_reset();
        #2;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: s_ready=%b m_valid=%b required 1/0", s_ready, m_valid);
        end
    endtask

    task automatic test_nominal();
        int m0;
        for (int i = 0; i < 64; i++) vals[i] = 8'(i * 5);
        m0 = mv_seen;
        send(48, 0);
        expect_frame(0);
        idle();
        total++;
        if (mv_seen - m0 != 1) begin
            bad++;
            $display("FAIL nominal_valid_cycles: saw %0d required 1", mv_seen - m0);
        end
        check_slot(0, 2'd0);
        check_slot(4, 2'd1);
        check_slot(13, 2'd2);
        check_slot(32, 2'd3);
    endtask

    task automatic test_thresholds();
        logic [7:0] x [7];
        logic [1:0] c [7];
        x = '{8'd15, 8'd16, 8'd63, 8'd64, 8'd159, 8'd160, 8'd255};
        c = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        randomize_vals();
        for (int i = 0; i < 7; i++) vals[i] = x[i];
        send(48, 0);
        expect_frame(0);
        for (int i = 0; i < 7; i++) check_slot(i, c[i]);
    endtask

    task automatic test_backpressure();
        randomize_vals();
        send(48, 0);
        expect_frame(10);
        randomize_vals();
        send(48, 0);
        expect_frame(0);
    endtask

    task automatic test_short();
        int e0, m0;
        randomize_vals();
        e0 = err_seen;
        m0 = mv_seen;
        send(21, 0);
        idle();
        total++;
        if (err_frame !== 1'b1) begin
            bad++;
            $display("FAIL short_err: err_frame=%b required 1", err_frame);
        end
        idle();
        idle();
        total++;
        if (err_seen - e0 != 1 || mv_seen - m0 != 0) begin
            bad++;
            $display("FAIL short_counts: err pulses=%0d m_valid cycles=%0d required 1/0", err_seen - e0, mv_seen - m0);
        end
        randomize_vals();
        send(48, 0);
        expect_frame(0);
    endtask

    task automatic test_long();
        int e0, m0;
        randomize_vals();
        e0 = err_seen;
        m0 = mv_seen;
        for (int i = 0; i < 60; i++) begin
            beat(vals[i], i == 59);
            if (i == 48) begin
                total++;
                if (err_frame !== 1'b1) begin
                    bad++;
                    $display("FAIL long_err: err_frame=%b required 1 after beat 47", err_frame);
                end
            end
        end
        idle();
        idle();
        total++;
        if (err_seen - e0 != 1 || mv_seen - m0 != 0) begin
            bad++;
            $display("FAIL long_counts: err pulses=%0d m_valid cycles=%0d required 1/0", err_seen - e0, mv_seen - m0);
        end
        randomize_vals();
        send(48, 0);
        expect_frame(0);
    endtask

    task automatic test_reset_mid();
        randomize_vals();
        for (int i = 0; i < 31; i++) beat(vals[i], 1'b0);
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_mid_frame");
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        randomize_vals();
        send(48, 0);
        expect_frame(0);
        randomize_vals();
        send(48, 0);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        total++;
        if (m_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_hold_pre: m_valid=%b required 1", m_valid);
        end
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_in_hold");
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b1;
        randomize_vals();
        send(21, 0);
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_err_pulse");
        @(negedge clk);
        rst = 1'b1;
        randomize_vals();
        send(48, 0);
        expect_frame(0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            randomize_vals();
            send(48, 1);
            expect_frame($urandom_range(0, 4));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_thresholds();
        test_backpressure();
        test_short();
        test_long();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
